srl16_fifo_ctl: RTL and testbench

Control block for an SRL16-based FIFO. It sequences a bank of addressable 16-stage shift registers, one SRL16E per data bit, which sits outside this block.
- It generates the shift enable and read address for the bank.
- It tracks occupancy and provides valid/ready handshakes on both sides.
- It holds one registered output word.
- It is used as a small elastic buffer between DSP pipeline stages running on one clock.

---
 rtl/srl16_fifo_ctl.sv | 116 +++++++++++
 tb/tb_srl16_fifo_ctl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/srl16_fifo_ctl.sv
// rtl/srl16_fifo_ctl.sv - control block for an SRL16E-based elastic FIFO
//
// Sequences an external bank of SRL16E shift registers (one per data bit)
// and owns a single registered output word. Total capacity is 16 words
// in the SRL plus 1 in the output register.
//
// Optional build macro: SRL16_FIFO_BYPASS_EN
//   defined   - a word pushed into an empty FIFO whose output register is
//               free (or draining) goes straight to out_data, skipping the SRL.
//   undefined - every word passes through the SRL (2-edge empty latency).
//
// Parameters:
//   WIDTH      data width of the SRL bank and output register
//   AFULL_LVL  occupancy (1..17) at or above which afull asserts
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   producer word present on in_data
//   in_ready   FIFO accepts a word this cycle
//   in_data    producer word (also wired to the SRL bank d inputs)
//   srl_ce     SRL bank shift enable
//   srl_a      SRL bank read address, always the oldest stored word
//   srl_y      SRL bank addressed output (combinational)
//   out_data   registered output word
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts out_data this cycle
//   count      total occupancy, SRL words + out_valid (0..17)
//   afull      count >= AFULL_LVL

module srl16_fifo_ctl #(
    parameter int WIDTH     = 2,
    parameter int AFULL_LVL = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             srl_ce,
    output logic [3:0]       srl_a,
    input  logic [WIDTH-1:0] srl_y,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       count,
    output logic             afull
);

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] AFULL_TH = 5'(AFULL_LVL);

    logic [4:0] cnt;        // words held in the SRL bank, 0..16
    logic       run;        // low until the first edge after reset release
    logic       push;
    logic       ld;
    logic       byp;
    logic       out_free;   // output register can take a word this edge
    logic [4:0] cnt_m1;

    // in_ready depends on state only, so a full SRL blocks the producer even
    // while the consumer is draining; it reopens once a load drops cnt.
    assign in_ready = run & (cnt != CNT_FULL);
    assign push     = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;
    assign ld       = (cnt != 5'd0) & out_free;

`ifdef SRL16_FIFO_BYPASS_EN
    // cnt==0 implies ld==0, so bypass and SRL load never compete.
    assign byp = push & (cnt == 5'd0) & out_free;
`else
    logic unused_in_data;
    assign byp            = 1'b0;
    assign unused_in_data = ^in_data;
`endif

    assign srl_ce = push & ~byp;

    // The newest word enters stage 0, so the oldest sits at stage cnt-1.
    assign cnt_m1 = cnt - 5'd1;
    assign srl_a  = (cnt == 5'd0) ? 4'd0 : cnt_m1[3:0];

    assign count = cnt + {4'd0, out_valid};
    assign afull = (count >= AFULL_TH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            cnt       <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            run <= 1'b1;

            // Shift and load on the same edge cancel; srl_a stays put.
            case ({srl_ce, ld})
                2'b10:   cnt <= cnt + 5'd1;
                2'b01:   cnt <= cnt - 5'd1;
                default: cnt <= cnt;
            endcase

            // srl_y reflects pre-edge SRL contents, so a simultaneous
            // shift cannot corrupt the word being loaded.
            if (ld) begin
                out_data  <= srl_y;
                out_valid <= 1'b1;
            end else if (byp) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_srl16_fifo_ctl.sv
// tb/tb_srl16_fifo_ctl.sv - scoreboard bench for srl16_fifo_ctl with SRL16E bank model

module tb_srl16_fifo_ctl;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             srl_ce;
    logic [3:0]       srl_a;
    logic [WIDTH-1:0] srl_y;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       count;
    logic             afull;

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] srl_mem[16];

`ifdef SRL16_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    srl16_fifo_ctl #(.WIDTH(WIDTH), .AFULL_LVL(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .srl_ce(srl_ce), .srl_a(srl_a), .srl_y(srl_y),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .afull(afull)
    );

    always #5 clk = ~clk;

    // SRL16E bank model; preset with 2'b11 so stale contents are recognisable.
    initial for (int i = 0; i < 16; i++) srl_mem[i] = 2'b11;
    always @(posedge clk) begin
        if (srl_ce) begin
            for (int i = 15; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= in_data;
        end
    end
    assign srl_y = srl_mem[srl_a];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((out_valid || count != 5'd0) && n < 60) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(n < 60), 32'd1);
    endtask

    // Monitor: record accepted pushes and compare accepted outputs, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("sb_out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (srl_ce) ce_cnt++;
        end
    end

    initial begin
        int ce0;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);
        step();
        check("rst_in_ready_held", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready_release", 32'(in_ready), 32'd1);
        check("rst_srl_a", 32'(srl_a), 32'd0);

        // Single word
        out_ready = 1'b1; in_valid = 1'b1; in_data = 2'b10;
        ce0 = ce_cnt;
        step();
        in_valid = 1'b0;
        if (!BYP) begin
            check("single_e1_valid", 32'(out_valid), 32'd0);
            step();
        end
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'd2);
        step();
        check("single_gone", 32'(out_valid), 32'd0);
        check("single_ce_pulses", 32'(ce_cnt - ce0), BYP ? 32'd0 : 32'd1);

        // Fill to 17
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 2'(i % 4);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_afull", 32'(afull), 32'((i + 1) >= 12));
        end
        in_data = 2'b01;
        check("full_in_ready", 32'(in_ready), 32'd0);
        ce0 = ce_cnt;
        step();
        check("full_ce_idle", 32'(ce_cnt - ce0), 32'd0);
        check("full_count", 32'(count), 32'd17);
        in_valid = 1'b0;

        // Drain from full
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            check("drain_srl_a", 32'(srl_a), (k < 16) ? 32'(15 - k) : 32'd0);
            check("drain_data", 32'(out_data), 32'(k % 4));
            step();
            if (k == 0) check("drain_in_ready", 32'(in_ready), 32'd1);
        end
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Simultaneous push and pop at cnt=8
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 2'(i % 4);
            step();
        end
        in_valid = 1'b0;
        check("sim_pre_count", 32'(count), 32'd9);
        check("sim_pre_srl_a", 32'(srl_a), 32'd7);
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 2'(j % 4);
            step();
            check("sim_srl_a", 32'(srl_a), 32'd7);
            check("sim_count", 32'(count), 32'd9);
        end
        in_valid = 1'b0;
        wait_drain();

        // Stall with output held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 2'b11;
        step();
        in_valid = 1'b0;
        if (!BYP) step();
        check("stall_count0", 32'(count), 32'd1);
        for (int s = 0; s < 5; s++) begin
            in_valid = (s < 3); in_data = 2'(s);
            step();
            check("stall_data", 32'(out_data), 32'd3);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        check("stall_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        wait_drain();

        // Mid-stream asynchronous reset with cnt=5, out_valid=1
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 2'(i % 4);
            step();
        end
        in_valid = 1'b0;
        check("mid_pre_count", 32'(count), 32'd6);
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_afull", 32'(afull), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_srl_a", 32'(srl_a), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 2'b01;
        step();
        in_valid = 1'b0;
        if (!BYP) step();
        check("post_rst_data", 32'(out_data), 32'd1);
        wait_drain();

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
